// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared state, opcode and datapath select encodings for the multicycle ARM controller
package arm_mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } stateT;
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/arm_mc_controller_if.sv
// arm_mc_controller_if: instruction fields and ALU flags in, datapath enables and selects out
interface arm_mc_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
               ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
               ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/arm_condlogic.sv
// arm_condlogic: NZCV flag register, condition evaluation and gating of architectural writes
module arm_condlogic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);
    logic [3:0] flags;
    logic       n, z, c, v, condEx, condExD;
    assign {n, z, c, v} = flags;
    always_comb begin
        case (Cond)
            4'b0000: condEx = z;
            4'b0001: condEx = !z;
            4'b0010: condEx = c;
            4'b0011: condEx = !c;
            4'b0100: condEx = n;
            4'b0101: condEx = !n;
            4'b0110: condEx = v;
            4'b0111: condEx = !v;
            4'b1000: condEx = c & !z;
            4'b1001: condEx = !c | z;
            4'b1010: condEx = n == v;
            4'b1011: condEx = n != v;
            4'b1100: condEx = !z & (n == v);
            4'b1101: condEx = z | (n != v);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end
    // condExD holds the verdict taken before this instruction's own flag update
    always_ff @(posedge clk) begin
        if (reset) begin
            flags   <= 4'b0000;
            condExD <= 1'b0;
        end else begin
            if (FlagW[1] & condEx) flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & condEx) flags[1:0] <= ALUFlags[1:0];
            condExD <= condEx;
        end
    end
    assign PCWrite  = !reset & ((PCS & condExD) | NextPC);
    assign RegWrite = !reset & RegW & condExD;
    assign MemWrite = !reset & MemW & condExD;
endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: Moore sequencer and ALU decode for the shared-memory multicycle ARM datapath
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input logic clk,
    input logic reset,
    arm_mc_controller_if.slave bus
);
    stateT      stateQ, stateD;
    logic       irW, aluOp, nextPC, regW, memW, branch, pcs;
    logic       isAdd, isSub, isAnd, isOrr;
    logic [1:0] flagW;
    always_ff @(posedge clk) stateQ <= reset ? FETCH : stateD;
    always_comb begin
        stateD        = FETCH;
        irW           = 1'b0;
        aluOp         = 1'b0;
        nextPC        = 1'b0;
        regW          = 1'b0;
        memW          = 1'b0;
        branch        = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_REG;
        bus.ResultSrc = RES_ALUOUT;
        case (stateQ)
            FETCH: begin
                stateD        = DECODE;
                irW           = 1'b1;
                nextPC        = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                stateD        = bus.Op == OP_MEM ? MEMADR :
                                bus.Op == OP_DP  ? (bus.Funct[5] ? EXECUTEI : EXECUTER) :
                                bus.Op == OP_BR  ? BRANCH : FETCH;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                stateD      = bus.Funct[0] ? MEMRD : MEMWR;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                stateD     = MEMWB;
                bus.AdrSrc = 1'b1;
            end
            MEMWB: begin
                regW          = 1'b1;
                bus.ResultSrc = RES_DATA;
            end
            MEMWR: begin
                memW       = 1'b1;
                bus.AdrSrc = 1'b1;
            end
            EXECUTER: begin
                stateD = ALUWB;
                aluOp  = 1'b1;
            end
            EXECUTEI: begin
                stateD      = ALUWB;
                aluOp       = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
            end
            ALUWB: regW = 1'b1;
            BRANCH: begin
                branch        = 1'b1;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURESULT;
            end
            default: stateD = FETCH;
        endcase
    end
    assign isAdd = bus.Funct[4:1] == CMD_ADD;
    assign isSub = bus.Funct[4:1] == CMD_SUB;
    assign isAnd = bus.Funct[4:1] == CMD_AND;
    assign isOrr = bus.Funct[4:1] == CMD_ORR;
    assign bus.ALUControl = !aluOp ? ALU_ADD : isSub ? ALU_SUB : isAnd ? ALU_AND :
                            isOrr ? ALU_ORR : ALU_ADD;
    // unsupported cmds never touch the flags
    assign flagW = {bus.Funct[0] & aluOp & (isAdd | isSub | isAnd | isOrr),
                    bus.Funct[0] & aluOp & (isAdd | isSub)};
    assign pcs          = ((bus.Rd == 4'hF) & regW) | branch;
    assign bus.IRWrite  = irW & !reset;
    assign bus.ImmSrc   = bus.Op;
    assign bus.RegSrc   = {bus.Op == OP_MEM, bus.Op == OP_BR};
    arm_condlogic condLogic (
        .clk     (clk),
        .reset   (reset),
        .Cond    (bus.Cond),
        .ALUFlags(bus.ALUFlags),
        .FlagW   (flagW),
        .PCS     (pcs),
        .NextPC  (nextPC),
        .RegW    (regW),
        .MemW    (memW),
        .PCWrite (bus.PCWrite),
        .RegWrite(bus.RegWrite),
        .MemWrite(bus.MemWrite)
    );
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: per-cycle directed vectors for the multicycle ARM controller
module tb_arm_mc_controller;
    typedef struct {
        logic        rst;
        logic [19:0] ins;
        logic [11:0] exp;
    } vecT;
    // instruction fields: {Cond, Op, Funct, Rd, ALUFlags}
    localparam logic [19:0] STREQ = {4'b0000, 2'b01, 6'b011000, 4'd3,  4'b1111};
    localparam logic [19:0] STRAL = {4'b1110, 2'b01, 6'b011000, 4'd3,  4'b1111};
    localparam logic [19:0] ADDS  = {4'b1110, 2'b00, 6'b001001, 4'd1,  4'b0100};
    localparam logic [19:0] BEQ   = {4'b0000, 2'b10, 6'b000000, 4'd0,  4'b1111};
    localparam logic [19:0] LDR   = {4'b1110, 2'b01, 6'b011001, 4'd2,  4'b1111};
    localparam logic [19:0] SUBPC = {4'b1110, 2'b00, 6'b000100, 4'd15, 4'b1111};
    localparam logic [19:0] NOP3  = {4'b1110, 2'b11, 6'b000000, 4'd0,  4'b1111};
    localparam logic [19:0] ORRSI = {4'b1110, 2'b00, 6'b111001, 4'd4,  4'b1000};
    localparam logic [19:0] ANDEQ = {4'b0000, 2'b00, 6'b000000, 4'd5,  4'b1111};
    localparam logic [19:0] EORMI = {4'b0100, 2'b00, 6'b000011, 4'd6,  4'b0100};
    localparam logic [19:0] SUBS  = {4'b1110, 2'b00, 6'b000101, 4'd7,  4'b0010};
    localparam logic [19:0] BHI   = {4'b1000, 2'b10, 6'b000000, 4'd0,  4'b1111};
    // expected {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    localparam logic [11:0] F_RST = 12'b0_0_0_0_0_10_1_10_00;
    localparam logic [11:0] F     = 12'b1_0_0_1_0_10_1_10_00;
    localparam logic [11:0] D     = 12'b0_0_0_0_0_10_1_10_00;
    localparam logic [11:0] MA    = 12'b0_0_0_0_0_00_0_01_00;
    localparam logic [11:0] MR    = 12'b0_1_0_0_0_00_0_00_00;
    localparam logic [11:0] MWB   = 12'b0_0_0_0_1_01_0_00_00;
    localparam logic [11:0] MW0   = 12'b0_1_0_0_0_00_0_00_00;
    localparam logic [11:0] MW1   = 12'b0_1_1_0_0_00_0_00_00;
    localparam logic [11:0] EXADD = 12'b0_0_0_0_0_00_0_00_00;
    localparam logic [11:0] EXSUB = 12'b0_0_0_0_0_00_0_00_01;
    localparam logic [11:0] EXAND = 12'b0_0_0_0_0_00_0_00_10;
    localparam logic [11:0] EIORR = 12'b0_0_0_0_0_00_0_01_11;
    localparam logic [11:0] WB0   = 12'b0_0_0_0_0_00_0_00_00;
    localparam logic [11:0] WB1   = 12'b0_0_0_0_1_00_0_00_00;
    localparam logic [11:0] WBPC  = 12'b1_0_0_0_1_00_0_00_00;
    localparam logic [11:0] BR0   = 12'b0_0_0_0_0_10_0_01_00;
    localparam logic [11:0] BR1   = 12'b1_0_0_0_0_10_0_01_00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vecT  vecs[$];
    arm_mc_controller_if bus();
    arm_mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [19:0] ins, input logic [11:0] e);
        vecT v;
        v.rst = r;
        v.ins = ins;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [19:0] ins, input logic [11:0] e, input string name);
        logic [15:0] got, want;
        logic [1:0]  op;
        @(negedge clk);
        reset = r;
        {bus.Cond, bus.Op, bus.Funct, bus.Rd, bus.ALUFlags} = ins;
        op = ins[15:14];
        #1;
        got  = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
        want = {e, op, op == 2'b01, op == 2'b10};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    initial begin
        {bus.Cond, bus.Op, bus.Funct, bus.Rd, bus.ALUFlags} = STREQ;
        add(1, STREQ, F_RST); add(1, STREQ, F_RST);
        add(0, STREQ, F); add(0, STREQ, D); add(0, STREQ, MA); add(0, STREQ, MW0);
        add(0, ADDS, F); add(0, ADDS, D); add(0, ADDS, EXADD); add(0, ADDS, WB1);
        add(0, BEQ, F); add(0, BEQ, D); add(0, BEQ, BR1);
        add(0, LDR, F); add(0, LDR, D); add(0, LDR, MA); add(0, LDR, MR); add(0, LDR, MWB);
        add(0, STREQ, F); add(0, STREQ, D); add(0, STREQ, MA); add(0, STREQ, MW1);
        add(0, SUBPC, F); add(0, SUBPC, D); add(0, SUBPC, EXSUB); add(0, SUBPC, WBPC);
        add(0, NOP3, F); add(0, NOP3, D);
        add(0, ORRSI, F); add(0, ORRSI, D); add(0, ORRSI, EIORR); add(0, ORRSI, WB1);
        add(0, ANDEQ, F); add(0, ANDEQ, D); add(0, ANDEQ, EXAND); add(0, ANDEQ, WB0);
        add(0, EORMI, F); add(0, EORMI, D); add(0, EORMI, EXADD); add(0, EORMI, WB1);
        add(0, BEQ, F); add(0, BEQ, D); add(0, BEQ, BR0);
        add(0, SUBS, F); add(0, SUBS, D); add(0, SUBS, EXSUB); add(0, SUBS, WB1);
        add(0, BHI, F); add(0, BHI, D); add(0, BHI, BR1);
        @(posedge clk);
        foreach (vecs[i]) step(vecs[i].rst, vecs[i].ins, vecs[i].exp, $sformatf("vec%0d", i));
        // reset landing in MEMWR of a store that would otherwise write
        step(0, STRAL, F, "rst_fetch");
        step(0, STRAL, D, "rst_decode");
        step(0, STRAL, MA, "rst_memadr");
        step(1, STRAL, MW0, "rst_in_memwr");
        step(0, STRAL, F, "rst_refetch");
        // flags were cleared by that reset, so BHI (C=1,Z=0 before) must now fail
        step(0, BHI, D, "rst_bhi_decode");
        step(0, BHI, BR0, "rst_bhi_branch");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Control unit for the multicycle ARM datapath that replaces the single-cycle core under `top`. It decodes the latched instruction fields, sequences each instruction through a Moore state machine (fetch, decode, memory or execute, writeback), and evaluates ARM condition codes against a private NZCV flag register. It drives every enable and mux select of the shared-memory multicycle datapath and uses no memory handshake.

## Interface
Parameters: none; state and opcode encodings come from the shared package.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Cond` in 4: Instr[31:28].
- `Op` in 2: Instr[27:26].
- `Funct` in 6: Instr[25:20]. Bit 5 is I, bits 4:1 are cmd, bit 0 is S/L.
- `Rd` in 4: Instr[15:12].
- `ALUFlags` in 4: NZCV from the ALU in the current cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 1: ALU A select. 0 = Rn, 1 = PC.
- `ALUSrcB` out 2: ALU B select. 00 = Rm/WriteData, 01 = ExtImm, 10 = constant 4.
- `ALUControl` out 2: ALU op. 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- `ImmSrc` out 2: immediate extension select, equal to `Op`.
- `RegSrc` out 2: register read port selects. [0] = (Op==10), [1] = (Op==01).

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.

Signals asserted per state; all unlisted signals are 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10 (forms PC+8).
  - Op=01 goes to MEMADR.
  - Op=00 with Funct[5]=0 goes to EXECUTER.
  - Op=00 with Funct[5]=1 goes to EXECUTEI.
  - Op=10 goes to BRANCH.
  - Op=11 goes to FETCH (no-op).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Funct[0]=1 goes to MEMRD, otherwise MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state is FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. Next state is FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next state is ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1. Next state is FETCH.

ALU decode:
- ALUOp=0: ALUControl=00, FlagW=00.
- ALUOp=1, cmd 0100: ADD.
- ALUOp=1, cmd 0010: SUB.
- ALUOp=1, cmd 0000: AND.
- ALUOp=1, cmd 1100: ORR.
- ALUOp=1, any other cmd: ALUControl=00 and FlagW=00.
- FlagW[1] (NZ) = Funct[0] & ALUOp.
- FlagW[0] (CV) = Funct[0] & ALUOp & (ADD or SUB).

Condition logic:
- CondEx covers the standard codes 0000–1110 against the stored NZCV. Cond 1110 (AL) is 1; cond 1111 is 0.
- N,Z update on a clock edge when FlagW[1] & CondEx. C,V update when FlagW[0] & CondEx.
- CondExD is a register that loads CondEx every cycle.
- PCS = ((Rd==1111) & RegW) | Branch.
- RegWrite = RegW & CondExD.
- MemWrite = MemW & CondExD.
- PCWrite = (PCS & CondExD) | NextPC.

## Timing
- Outputs are combinational from the state register and the instruction fields only; there is no path from ALUFlags to an output within one cycle.
- Cycle counts from FETCH to the next FETCH: B = 3, data-processing = 4, STR = 4, LDR = 5, Op=11 = 2.
- Flags written in EXECUTER/EXECUTEI are visible to CondEx in the next cycle. CondExD is therefore valid in ALUWB, MEMWR, MEMWB and BRANCH.
- Reset:
  - The edge sampling reset=1 sets state=FETCH, NZCV=0000, CondExD=0.
  - While `reset` is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0 combinationally.
  - A reset mid-instruction (any state) abandons that instruction with no further writes.
  - The first FETCH runs in the first cycle after reset falls.
- Unreachable state encodings go to FETCH.

## Structure
- Package `arm_mc_pkg` holds:
  - the state enum;
  - Op constants (DP=00, MEM=01, BR=10);
  - cmd constants (ADD, SUB, AND, ORR);
  - the ALUControl, ResultSrc and ALUSrcB encodings.
- Sub-module `arm_condlogic` holds the NZCV register, the CondEx decode, the CondExD register and the write gating.
- The FSM, ALU decode and PCS logic stay in the top module.

## Test plan
- Reset held for 2 cycles, then released:
  - all write enables are 0 during reset;
  - the first cycle after release is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001), then ALUFlags=0100:
  - states go FETCH→DECODE→EXECUTER→ALUWB with RegWrite=1 in ALUWB;
  - a following BEQ has PCWrite=1 in BRANCH.
- LDR (Op=01, Funct[0]=1): 5 states with AdrSrc=1 in MEMRD, and RegWrite=1 with ResultSrc=01 in MEMWB.
- STR (Op=01, Funct[0]=0) with Cond=0000 while Z=0: MemWrite stays 0 in MEMWR and the next state is FETCH.
- SUB PC,... (Rd=1111, Cond=1110): PCWrite=1 and RegWrite=1 in ALUWB.
- Reset asserted in MEMWR: MemWrite=0 in that cycle and state=FETCH next.
